// File: rtl/simd_mul_arbiter_pkg.sv
// Shared constants for the SIMD multiplier arbiter: lane mode encodings and lane widths.
package simd_mul_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int QUAD_W = 4;   // four 4-bit lanes
    localparam int OCT_W  = 8;   // two 8-bit lanes
    localparam int HALF_W = 16;  // one 16-bit lane

    typedef enum logic [1:0] {
        MODE_QUAD = 2'b00,
        MODE_OCT  = 2'b01,
        MODE_HALF = 2'b10,
        MODE_ILL  = 2'b11
    } mode_e;

endpackage

// File: rtl/SIMDmultiply.sv
// Combinational lane-wise unsigned multiplier; each lane product is truncated to its
// lane width so no carry crosses a lane boundary. No mode selected yields zero.
module SIMDmultiply
    import simd_mul_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              H,
    input  logic              O,
    input  logic              Q,
    output logic [DATA_W-1:0] p
);

    // Lane products selected by the one-hot H/O/Q decode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        p = '0;
        if (Q) begin
            for (int i = 0; i < DATA_W / QUAD_W; i++) begin
                p[i*QUAD_W +: QUAD_W] = a[i*QUAD_W +: QUAD_W] * b[i*QUAD_W +: QUAD_W];
            end
        end else if (O) begin
            for (int i = 0; i < DATA_W / OCT_W; i++) begin
                p[i*OCT_W +: OCT_W] = a[i*OCT_W +: OCT_W] * b[i*OCT_W +: OCT_W];
            end
        end else if (H) begin
            p[HALF_W-1:0] = a[HALF_W-1:0] * b[HALF_W-1:0];
        end
    end

endmodule

// File: rtl/simd_mul_arbiter.sv
// Two-requester arbiter feeding a two-stage SIMD multiply pipeline (S1 operands, S2 result)
// with valid/ready handshakes on both sides and a wrapping accepted-request counter.
module simd_mul_arbiter
    import simd_mul_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [1:0]        req_mode0,
    input  logic [1:0]        req_mode1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_src,
    output logic              res_err,
    output logic [15:0]       op_count
);

    // S1 stage
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    mode_e             s1_mode_q, s1_mode_d;
    logic              s1_src_q, s1_src_d;
    // S2 stage
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              s2_src_q, s2_src_d;
    logic              s2_err_q, s2_err_d;
    // Arbitration pointer: requester favoured when both are valid
    logic              prio_q, prio_d;
    logic [15:0]       op_count_q, op_count_d;

    logic              s2_load, s1_take, grant_any, grant_idx, accept;
    logic [DATA_W-1:0] prod;

    assign s2_load = s1_valid_q && (!s2_valid_q || res_ready);
    assign s1_take = !s1_valid_q || s2_load;

    // Grant selection and the combinational ready back to the requesters.
    always_comb begin
        grant_any = 1'b1;
        grant_idx = 1'b0;
        case (req_valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = RR_EN ? prio_q : 1'b0;
            default: grant_any = 1'b0;
        endcase
        req_ready = 2'b00;
        // ready is forced low while reset is held, even though the stages look empty then
        if (rst_n && s1_take && grant_any) begin
            req_ready = 2'b01 << grant_idx;
        end
    end

    assign accept = |(req_ready & req_valid);

    SIMDmultiply u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .H (s1_mode_q == MODE_HALF),
        .O (s1_mode_q == MODE_OCT),
        .Q (s1_mode_q == MODE_QUAD),
        .p (prod)
    );

    // Next-state for both pipeline stages, the pointer and the counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s1_src_d   = s1_src_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_src_d   = s2_src_q;
        s2_err_d   = s2_err_q;
        prio_d     = prio_q;
        op_count_d = op_count_q;

        if (s1_take) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d    = grant_idx ? req_a1 : req_a0;
                s1_b_d    = grant_idx ? req_b1 : req_b0;
                s1_mode_d = mode_e'(grant_idx ? req_mode1 : req_mode0);
                s1_src_d  = grant_idx;
            end
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = prod;
            s2_src_d   = s1_src_q;
            s2_err_d   = (s1_mode_q == MODE_ILL);
        end else if (res_ready) begin
            s2_valid_d = 1'b0;
        end

        if (accept) begin
            prio_d     = ~grant_idx;
            op_count_d = op_count_q + 16'd1;
        end
    end

    // State registers; the datapath is reset too so outputs read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= MODE_QUAD;
            s1_src_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_src_q   <= 1'b0;
            s2_err_q   <= 1'b0;
            prio_q     <= 1'b0;
            op_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s1_src_q   <= s1_src_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_src_q   <= s2_src_d;
            s2_err_q   <= s2_err_d;
            prio_q     <= prio_d;
            op_count_q <= op_count_d;
        end
    end

    assign res_valid = s2_valid_q;
    assign res_data  = s2_data_q;
    assign res_src   = s2_src_q;
    assign res_err   = s2_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_simd_mul_arbiter.sv
// Directed bench for simd_mul_arbiter: a round-robin instance and a fixed-priority instance
// share all inputs. Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_simd_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_mode0, req_mode1;
    logic        res_ready;

    logic [1:0]  rr_req_ready, fp_req_ready;
    logic        rr_res_valid, fp_res_valid;
    logic [15:0] rr_res_data, fp_res_data;
    logic        rr_res_src, fp_res_src;
    logic        rr_res_err, fp_res_err;
    logic [15:0] rr_op_count, fp_op_count;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    simd_mul_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr_req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_mode0(req_mode0), .req_mode1(req_mode1),
        .res_valid(rr_res_valid), .res_ready(res_ready), .res_data(rr_res_data),
        .res_src(rr_res_src), .res_err(rr_res_err), .op_count(rr_op_count)
    );

    simd_mul_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_mode0(req_mode0), .req_mode1(req_mode1),
        .res_valid(fp_res_valid), .res_ready(res_ready), .res_data(fp_res_data),
        .res_src(fp_res_src), .res_err(fp_res_err), .op_count(fp_op_count)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 2'b00; res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 16'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; res_ready = 1'b1;
        req_a0 = 16'h0; req_b0 = 16'h0; req_a1 = 16'h0; req_b1 = 16'h0;
        req_mode0 = 2'b00; req_mode1 = 2'b00;
        #1;
        n_vec++; if (rr_req_ready !== 2'b00) begin n_miss++; $display("FAIL reset_ready: got %b want 00", rr_req_ready); end
        n_vec++; if (fp_req_ready !== 2'b00) begin n_miss++; $display("FAIL reset_ready_fp: got %b want 00", fp_req_ready); end
        n_vec++; if (rr_res_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b want 0", rr_res_valid); end
        n_vec++; if (rr_res_data !== 16'h0000) begin n_miss++; $display("FAIL reset_data: got %h want 0000", rr_res_data); end
        n_vec++; if ({rr_res_src, rr_res_err} !== 2'b00) begin n_miss++; $display("FAIL reset_src_err: got %b want 00", {rr_res_src, rr_res_err}); end
        n_vec++; if (rr_op_count !== 16'h0000) begin n_miss++; $display("FAIL reset_count: got %h want 0000", rr_op_count); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00;
        exp_cnt = 16'd0;
    endtask

    task automatic test_mode(input logic [1:0] mode, input logic [15:0] exp_data, input string name);
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 16'h1234; req_b0 = 16'h5678; req_mode0 = mode; res_ready = 1'b1;
        #1;
        n_vec++; if (rr_req_ready !== 2'b01) begin n_miss++; $display("FAIL %s_ready: got %b want 01", name, rr_req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_vec++; if (rr_res_valid !== 1'b0) begin n_miss++; $display("FAIL %s_latency1: got valid %b want 0", name, rr_res_valid); end
        @(negedge clk);
        #1;
        exp_cnt++;
        n_vec++; if (rr_res_valid !== 1'b1) begin n_miss++; $display("FAIL %s_valid: got %b want 1", name, rr_res_valid); end
        n_vec++; if (rr_res_data !== exp_data) begin n_miss++; $display("FAIL %s_data: got %h want %h", name, rr_res_data, exp_data); end
        n_vec++; if ({rr_res_src, rr_res_err} !== 2'b00) begin n_miss++; $display("FAIL %s_src_err: got %b want 00", name, {rr_res_src, rr_res_err}); end
        n_vec++; if (rr_op_count !== exp_cnt) begin n_miss++; $display("FAIL %s_count: got %h want %h", name, rr_op_count, exp_cnt); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        req_valid = 2'b10; req_a1 = 16'hFFFF; req_b1 = 16'hFFFF; req_mode1 = 2'b11; res_ready = 1'b1;
        #1;
        n_vec++; if (rr_req_ready !== 2'b10) begin n_miss++; $display("FAIL ill_ready: got %b want 10", rr_req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        exp_cnt++;
        n_vec++; if (rr_res_valid !== 1'b1) begin n_miss++; $display("FAIL ill_valid: got %b want 1", rr_res_valid); end
        n_vec++; if (rr_res_data !== 16'h0000) begin n_miss++; $display("FAIL ill_data: got %h want 0000", rr_res_data); end
        n_vec++; if ({rr_res_src, rr_res_err} !== 2'b11) begin n_miss++; $display("FAIL ill_src_err: got %b want 11", {rr_res_src, rr_res_err}); end
        n_vec++; if (rr_op_count !== exp_cnt) begin n_miss++; $display("FAIL ill_count: got %h want %h", rr_op_count, exp_cnt); end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_rdy;
        logic       exp_src;
        do_reset();
        req_a0 = 16'h1111; req_b0 = 16'h2222; req_mode0 = 2'b00;
        req_a1 = 16'h3333; req_b1 = 16'h1111; req_mode1 = 2'b00;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            req_valid = (t < 4) ? 2'b11 : 2'b00;
            #1;
            if (t < 4) begin
                exp_rdy = (t % 2 == 0) ? 2'b01 : 2'b10;
                n_vec++; if (rr_req_ready !== exp_rdy) begin n_miss++; $display("FAIL rr_grant%0d: got %b want %b", t, rr_req_ready, exp_rdy); end
                n_vec++; if (fp_req_ready !== 2'b01) begin n_miss++; $display("FAIL fp_grant%0d: got %b want 01", t, fp_req_ready); end
            end
            if (t >= 2) begin
                exp_src = ((t - 2) % 2 == 1);
                n_vec++; if ({rr_res_valid, rr_res_src} !== {1'b1, exp_src}) begin n_miss++; $display("FAIL rr_src%0d: got %b want %b", t - 2, {rr_res_valid, rr_res_src}, {1'b1, exp_src}); end
                n_vec++; if ({fp_res_valid, fp_res_src} !== 2'b10) begin n_miss++; $display("FAIL fp_src%0d: got %b want 10", t - 2, {fp_res_valid, fp_res_src}); end
            end
        end
        n_vec++; if (rr_op_count !== 16'd4) begin n_miss++; $display("FAIL rr_count: got %h want 0004", rr_op_count); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        do_reset();
        req_b0 = 16'h1111; req_mode0 = 2'b00;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            req_valid = 2'b01; res_ready = 1'b0; req_a0 = 16'h0002 + 16'(acc);
            #1;
            if (rr_req_ready[0]) acc++;
            if (t >= 2) begin
                n_vec++; if (rr_req_ready !== 2'b00) begin n_miss++; $display("FAIL bp_ready%0d: got %b want 00", t, rr_req_ready); end
                n_vec++; if ({rr_res_valid, rr_res_src, rr_res_err, rr_res_data} !== {3'b100, 16'h0002}) begin
                    n_miss++; $display("FAIL bp_hold%0d: got v%b s%b e%b %h want v1 s0 e0 0002", t, rr_res_valid, rr_res_src, rr_res_err, rr_res_data);
                end
            end
        end
        n_vec++; if (acc != 2) begin n_miss++; $display("FAIL bp_accepts: got %0d want 2", acc); end
        @(negedge clk);
        req_valid = 2'b00; res_ready = 1'b1;
        #1;
        n_vec++; if ({rr_res_valid, rr_res_data} !== {1'b1, 16'h0002}) begin n_miss++; $display("FAIL bp_drain0: got %b %h want 1 0002", rr_res_valid, rr_res_data); end
        @(negedge clk);
        #1;
        n_vec++; if ({rr_res_valid, rr_res_data} !== {1'b1, 16'h0003}) begin n_miss++; $display("FAIL bp_drain1: got %b %h want 1 0003", rr_res_valid, rr_res_data); end
        @(negedge clk);
        #1;
        n_vec++; if (rr_res_valid !== 1'b0) begin n_miss++; $display("FAIL bp_nodup: got valid %b want 0", rr_res_valid); end
        n_vec++; if (rr_op_count !== 16'd2) begin n_miss++; $display("FAIL bp_count: got %h want 0002", rr_op_count); end
    endtask

    task automatic test_count_wrap();
        int acc = 0;
        int cyc = 0;
        do_reset();
        req_a0 = 16'h0001; req_b0 = 16'h0001; req_mode0 = 2'b10; res_ready = 1'b1;
        while (acc < 65535 && cyc < 70000) begin
            @(negedge clk);
            req_valid = 2'b01;
            #1;
            if (rr_req_ready[0]) acc++;
            cyc++;
        end
        n_vec++; if (acc != 65535) begin n_miss++; $display("FAIL wrap_budget: got %0d accepts want 65535", acc); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_vec++; if (rr_op_count !== 16'hFFFF) begin n_miss++; $display("FAIL wrap_full: got %h want ffff", rr_op_count); end
        @(negedge clk);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_vec++; if (rr_op_count !== 16'h0000) begin n_miss++; $display("FAIL wrap_zero: got %h want 0000", rr_op_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_b0 = 16'h1111; req_mode0 = 2'b00; res_ready = 1'b0;
        @(negedge clk); req_valid = 2'b01; req_a0 = 16'h0005;
        @(negedge clk); req_valid = 2'b01; req_a0 = 16'h0006;
        @(negedge clk); req_valid = 2'b00;
        #1;
        n_vec++; if ({rr_res_valid, rr_res_data} !== {1'b1, 16'h0005}) begin n_miss++; $display("FAIL mid_full: got %b %h want 1 0005", rr_res_valid, rr_res_data); end
        rst_n = 1'b0; req_valid = 2'b01;
        #1;
        n_vec++; if ({rr_res_valid, rr_res_data, rr_op_count} !== {1'b0, 16'h0000, 16'h0000}) begin
            n_miss++; $display("FAIL mid_rst: got v%b %h cnt %h want v0 0000 0000", rr_res_valid, rr_res_data, rr_op_count);
        end
        n_vec++; if (rr_req_ready !== 2'b00) begin n_miss++; $display("FAIL mid_rst_ready: got %b want 00", rr_req_ready); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00; res_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            #1;
            n_vec++; if (rr_res_valid !== 1'b0) begin n_miss++; $display("FAIL mid_stale%0d: got valid %b want 0", t, rr_res_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_mode(2'b00, 16'h5C50, "quad");
        test_mode(2'b01, 16'h0C60, "oct");
        test_mode(2'b10, 16'h0060, "half");
        test_illegal();
        test_arbitration();
        test_backpressure();
        test_count_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/simd_mul_arbiter.md
SIMD_MUL_ARBITER -- requirements
Module: simd_mul_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 Port: clk  in  1  single clock; all state rising-edge triggered.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid[1:0]  in  2  per-requester request valid.
REQ-005 Port: req_ready[1:0]  out  2  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-006 Port: req_a0, req_b0, req_a1, req_b1  in  16 each  operands of requester 0 and requester 1.
REQ-007 Port: req_mode0, req_mode1  in  2 each  lane mode: 00 quad (4x4-bit), 01 octet (2x8-bit), 10 half (1x16-bit), 11 illegal.
REQ-008 Port: res_valid  out  1  result valid.
REQ-009 Port: res_ready  in  1  downstream accept.
REQ-010 Port: res_data  out  16  lane-wise product.
REQ-011 Port: res_src  out  1  index of the requester that issued the result.
REQ-012 Port: res_err  out  1  result came from an illegal mode.
REQ-013 Port: op_count  out  16  count of accepted requests, wraps 16'hFFFF -> 16'h0000.

Function
REQ-014 Two registered stages: S1 (operands, mode, src) and S2 (result, src, err); each stage has its own valid bit.
REQ-015 S2 loads from S1 when S1 is valid and either S2 is empty or res_ready=1 in the same cycle.
REQ-016 S1 accepts a new request when S1 is empty or S1 advances into S2 in the same cycle.
REQ-017 At most one req_ready bit is high in any cycle; it is high only for the granted requester, and only when S1 can accept (REQ-016).
REQ-018 req_ready is combinational from req_valid, the arbitration pointer and the stage state; it is never high while req_valid of the same requester is low.
REQ-019 Round-robin: if both requesters are valid, grant goes to the requester not granted last; the pointer updates only on an accepted transfer.
REQ-020 Fixed priority (RR_EN=0): requester 0 wins whenever both are valid.
REQ-021 Latency: a request accepted in cycle N gives res_valid=1 in cycle N+2 when unstalled; throughput is one result per cycle.
REQ-022 While res_valid=1 and res_ready=0, res_data, res_src and res_err stay stable.
REQ-023 Arithmetic: unsigned per-lane product, truncated to the lane width; there is no carry between lanes.
REQ-024 Illegal mode (11) is accepted normally; it produces res_data=16'h0000 and res_err=1.
REQ-025 op_count increments once per accepted request, including illegal-mode requests.
REQ-026 The stage valid bits and the arbitration pointer are the only control state; there is no other FSM.

Reset
REQ-027 When rst_n is low: S1/S2 valid=0, res_valid=0, res_data=0, res_src=0, res_err=0, op_count=0, pointer favours requester 0, and req_ready=0.
REQ-028 Reset asserted mid-operation discards in-flight operations; no result is emitted for them after release.

Structure
REQ-029 A shared package holds the mode encoding constants (MODE_QUAD, MODE_OCT, MODE_HALF, MODE_ILL) and the lane width localparams.
REQ-030 The combinational lane multiplier is instantiated as one sub-module, SIMDmultiply, between S1 and S2; H/O/Q are decoded from the S1 mode.

Verification
REQ-031 Requester 0 sends a=16'h1234, b=16'h5678, mode quad, with res_ready=1 -> res_data=16'h5C50, res_src=0, res_err=0, two cycles after the accept.
REQ-032 Same operands in octet mode -> 16'h0C60; in half mode -> 16'h0060.
REQ-033 Both requesters valid for 4 cycles with RR_EN=1 -> grants are 0,1,0,1 and res_src follows the same order; with RR_EN=0 -> all four grants go to 0.
REQ-034 res_ready held low for 5 cycles with continuous requests -> exactly 2 accepts, then req_ready=0; outputs stay stable; on release the results drain in order with no loss or duplication.
REQ-035 Illegal mode 11 from requester 1 -> res_data=16'h0000, res_err=1, and op_count increments.
REQ-036 op_count preset by 65535 accepts, then 1 more -> 16'h0000; rst_n pulsed low with both stages full -> res_valid=0 immediately, and no stale result appears after release.
